// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the tomato vending chain (credit accumulator,
// select decoder, dispenser).
//   state_t          : credit FSM states IDLE / VEND / REFUND
//   CW               : width of the credit bus
//   MAX_CREDIT       : credit saturation ceiling, in units
//   TOMATO_PRICE     : units deducted per vend
//   DEBOUNCE_CYCLES  : consecutive high samples that register one coin
// ---------------------------------------------------------------------------
package vend_pkg;

    localparam int CW              = 4;
    localparam int MAX_CREDIT      = 8;
    localparam int TOMATO_PRICE    = 5;
    localparam int DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        REFUND = 2'd2
    } state_t;

endpackage

// File: rtl/coin_credit_accumulator_if.sv
// ---------------------------------------------------------------------------
// coin_credit_accumulator_if
// Bundles the coin/request inputs and the credit/pulse outputs of the
// credit accumulator.
//   coin_raw, coin_val      : coin sensor level and coin value (1..3, 0 = bad)
//   vend_req, refund_req    : level requests
//   credit                  : current credit, bits feed decoder a3..a0
//   vend_ack, coin_reject,
//   return_pulse            : registered one-cycle pulses
//   state                   : FSM state, exposed for observation
// Handshake: requests are plain levels sampled on every rising edge; there
// is no ready signal. A request that cannot be served in IDLE is dropped,
// and the caller learns the outcome only from vend_ack / return_pulse.
// Modports: master drives the inputs (vending front-end / bench), slave is
// the accumulator.
// ---------------------------------------------------------------------------
interface coin_credit_accumulator_if #(
    parameter int CW = vend_pkg::CW
);
    logic                 coin_raw;
    logic [1:0]           coin_val;
    logic                 vend_req;
    logic                 refund_req;
    logic [CW-1:0]        credit;
    logic                 vend_ack;
    logic                 coin_reject;
    logic                 return_pulse;
    vend_pkg::state_t     state;

    modport master (
        output coin_raw, coin_val, vend_req, refund_req,
        input  credit, vend_ack, coin_reject, return_pulse, state
    );

    modport slave (
        input  coin_raw, coin_val, vend_req, refund_req,
        output credit, vend_ack, coin_reject, return_pulse, state
    );
endinterface

// File: rtl/coin_debounce.sv
// ---------------------------------------------------------------------------
// coin_debounce
// Turns the coin sensor level into a single coin event.
//   clk, reset : clock, synchronous active-high reset
//   coin_raw   : sensor level
//   coin_val   : coin value, passed through with the event
//   coin_evt   : high during the cycle whose rising edge is the
//                DEBOUNCE_CYCLES-th consecutive high sample
//   evt_val    : coin value to be sampled on that same edge
// ---------------------------------------------------------------------------
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = vend_pkg::DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_raw,
    input  logic [1:0] coin_val,
    output logic       coin_evt,
    output logic [1:0] evt_val
);
    localparam int NW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NW-1:0] CNT_MAX = NW'(DEBOUNCE_CYCLES);

    logic [NW-1:0] cnt_q, cnt_d;

    // The count parks at CNT_MAX while the sensor stays high, which is what
    // blocks a second event until a low sample clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!coin_raw) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Event is combinational so the consumer acts on the same edge that
    // completes the count.
    assign coin_evt = coin_raw && (cnt_q == CNT_MAX - NW'(1));
    assign evt_val  = coin_val;

endmodule

// File: rtl/coin_credit_accumulator.sv
// ---------------------------------------------------------------------------
// coin_credit_accumulator
// Debounces coins, accumulates credit (0..MAX_CREDIT) and runs vend and
// refund transactions. All outputs are registered.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; aborts any vend/refund, drops credit
//   bus    : coin_credit_accumulator_if.slave (inputs coin_raw, coin_val,
//            vend_req, refund_req; outputs credit, vend_ack, coin_reject,
//            return_pulse, state)
// ---------------------------------------------------------------------------
module coin_credit_accumulator
    import vend_pkg::*;
#(
    parameter int CW              = vend_pkg::CW,
    parameter int MAX_CREDIT      = vend_pkg::MAX_CREDIT,
    parameter int TOMATO_PRICE    = vend_pkg::TOMATO_PRICE,
    parameter int DEBOUNCE_CYCLES = vend_pkg::DEBOUNCE_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    coin_credit_accumulator_if.slave    bus
);
    localparam logic [CW:0]   MAX_W   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] PRICE_W = CW'(TOMATO_PRICE);
    localparam logic [CW-1:0] ONE_W   = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          vend_ack_q, vend_ack_d;
    logic          coin_reject_q, coin_reject_d;
    logic          return_pulse_q, return_pulse_d;

    logic          coin_evt;
    logic [1:0]    evt_val;
    logic [CW:0]   coin_sum;
    logic          coin_ok;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .coin_raw (bus.coin_raw),
        .coin_val (bus.coin_val),
        .coin_evt (coin_evt),
        .evt_val  (evt_val)
    );

    // One bit wider than the bus so an over-ceiling sum is seen, not wrapped.
    assign coin_sum = {1'b0, credit_q} + {{(CW-1){1'b0}}, evt_val};

    // A coin is only credited when nothing else wants to move the credit in
    // the same cycle.
    assign coin_ok = (state_q == IDLE) && !bus.vend_req && !bus.refund_req &&
                     (evt_val != 2'd0) && (coin_sum <= MAX_W);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_ack_d     = 1'b0;
        coin_reject_d  = 1'b0;
        return_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.vend_req && (credit_q >= PRICE_W)) begin
                    state_d    = VEND;
                    credit_d   = credit_q - PRICE_W;
                    vend_ack_d = 1'b1;
                end else if (bus.refund_req && (credit_q != '0)) begin
                    // First unit is paid on the accepting edge; a one-unit
                    // refund therefore never leaves IDLE.
                    credit_d       = credit_q - ONE_W;
                    return_pulse_d = 1'b1;
                    state_d        = (credit_q == ONE_W) ? IDLE : REFUND;
                end
            end
            VEND: begin
                state_d = IDLE;
            end
            REFUND: begin
                credit_d       = credit_q - ONE_W;
                return_pulse_d = 1'b1;
                state_d        = (credit_q == ONE_W) ? IDLE : REFUND;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (coin_evt) begin
            if (coin_ok) begin
                credit_d = coin_sum[CW-1:0];
            end else begin
                coin_reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vend_ack_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            return_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_ack_q     <= vend_ack_d;
            coin_reject_q  <= coin_reject_d;
            return_pulse_q <= return_pulse_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.vend_ack     = vend_ack_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.return_pulse = return_pulse_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
module tb_coin_credit_accumulator;
    import vend_pkg::*;

    localparam int PRICE = vend_pkg::TOMATO_PRICE;
    localparam int MAXC  = vend_pkg::MAX_CREDIT;
    localparam int DEB   = vend_pkg::DEBOUNCE_CYCLES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    coin_credit_accumulator_if bus ();

    coin_credit_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Credit as a plain integer; a refund is "units still owed", a vend is
    // "vending this cycle"; the sensor is tracked as the length of the
    // current high run.
    int     m_credit = 0;
    int     m_run = 0;
    int     m_owed = 0;
    bit     m_vending = 0;
    bit     m_ack = 0, m_rej = 0, m_ret = 0;
    bit     m_valid = 0;
    bit     m_evt, m_busy;
    int     m_base;
    state_t m_state;

    always @(posedge clk) begin
        if (reset) begin
            m_credit = 0; m_run = 0; m_owed = 0; m_vending = 0;
            m_ack = 0; m_rej = 0; m_ret = 0; m_valid = 1;
        end else begin
            m_evt  = bus.coin_raw && (m_run + 1 == DEB);
            m_busy = m_vending || (m_owed > 0);
            m_base = m_credit;
            m_run  = bus.coin_raw ? m_run + 1 : 0;
            m_ack = 0; m_rej = 0; m_ret = 0;
            if (m_vending) begin
                m_vending = 0;
            end else if (m_owed > 0) begin
                m_credit--; m_owed--; m_ret = 1;
            end else if (bus.vend_req && m_credit >= PRICE) begin
                m_credit -= PRICE; m_ack = 1; m_vending = 1;
            end else if (bus.refund_req && m_credit > 0) begin
                m_owed = m_credit - 1; m_credit--; m_ret = 1;
            end
            if (m_evt) begin
                if (!m_busy && !bus.vend_req && !bus.refund_req &&
                    bus.coin_val != 0 && m_base + int'(bus.coin_val) <= MAXC)
                    m_credit = m_base + int'(bus.coin_val);
                else
                    m_rej = 1;
            end
        end
        m_state = m_vending ? VEND : ((m_owed > 0) ? REFUND : IDLE);
    end

    // ---------------- compare process + pulse counters ----------------
    int n_ack = 0, n_rej = 0, n_ret = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("credit", int'(bus.credit), m_credit);
            chk("vend_ack", int'(bus.vend_ack), int'(m_ack));
            chk("coin_reject", int'(bus.coin_reject), int'(m_rej));
            chk("return_pulse", int'(bus.return_pulse), int'(m_ret));
            chk("state", int'(bus.state), int'(m_state));
            if (bus.vend_ack) n_ack++;
            if (bus.coin_reject) n_rej++;
            if (bus.return_pulse) n_ret++;
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the falling edge, clear of both edges.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic coin(input logic [1:0] val, input int len);
        step();
        bus.coin_raw = 1'b1;
        bus.coin_val = val;
        wait_cyc(len);
        bus.coin_raw = 1'b0;
        step();
    endtask

    task automatic req(input logic v, input logic r);
        step();
        bus.vend_req   = v;
        bus.refund_req = r;
        step();
        bus.vend_req   = 1'b0;
        bus.refund_req = 1'b0;
    endtask

    // Literal pin: both the DUT and the model must hit the hand value.
    task automatic lit(input string name, input int dut_v, input int exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, m_credit, exp);
    endtask

    task automatic drain();
        req(1'b0, 1'b1);
        wait_cyc(10);
        chk("drain_credit", int'(bus.credit), 0);
    endtask

    int r0, a0, t0;

    initial begin
        bus.coin_raw = 1'b0; bus.coin_val = 2'd0;
        bus.vend_req = 1'b0; bus.refund_req = 1'b0;
        wait_cyc(2);
        reset = 1'b0;
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_pulses", int'({bus.vend_ack, bus.coin_reject, bus.return_pulse}), 0);
        chk("rst_state", int'(bus.state), int'(IDLE));

        // Debounce and accumulation
        coin(2'd2, 4); lit("t2_c2", int'(bus.credit), 2);
        coin(2'd2, 4); lit("t2_c4", int'(bus.credit), 4);
        coin(2'd2, 4); lit("t2_c6", int'(bus.credit), 6);
        coin(2'd2, 3); lit("t2_glitch", int'(bus.credit), 6);
        coin(2'd2, 10); lit("t2_long", int'(bus.credit), 8);
        t0 = n_ret;
        drain();
        chk("t2_refund8", n_ret - t0, 8);

        // Rejections at the ceiling and for a bad value
        coin(2'd3, 4); coin(2'd3, 4); coin(2'd1, 4);
        lit("t3_c7", int'(bus.credit), 7);
        r0 = n_rej;
        coin(2'd2, 4); lit("t3_over", int'(bus.credit), 7);
        chk("t3_rej_over", n_rej - r0, 1);
        coin(2'd0, 4); lit("t3_zero", int'(bus.credit), 7);
        chk("t3_rej_zero", n_rej - r0, 2);
        coin(2'd1, 4); lit("t3_c8", int'(bus.credit), 8);
        coin(2'd1, 4); lit("t3_full", int'(bus.credit), 8);
        chk("t3_rej_full", n_rej - r0, 3);
        drain();

        // Vend with and without enough credit
        coin(2'd3, 4); coin(2'd3, 4);
        lit("t4_c6", int'(bus.credit), 6);
        req(1'b1, 1'b0);
        chk("t4_ack_lat", int'(bus.vend_ack), 1);
        lit("t4_c1", int'(bus.credit), 1);
        step();
        chk("t4_ack_gone", int'(bus.vend_ack), 0);
        coin(2'd3, 4); lit("t4_c4", int'(bus.credit), 4);
        a0 = n_ack;
        req(1'b1, 1'b0);
        wait_cyc(2);
        lit("t4_short", int'(bus.credit), 4);
        chk("t4_no_ack", n_ack - a0, 0);
        drain();

        // Refund of 3 with a coin landing mid-refund
        coin(2'd3, 4); lit("t5_c3", int'(bus.credit), 3);
        r0 = n_rej; t0 = n_ret;
        step(); bus.coin_raw = 1'b1; bus.coin_val = 2'd1;
        step(); step(); bus.refund_req = 1'b1;
        step(); bus.refund_req = 1'b0;
        lit("t5_c2", int'(bus.credit), 2);
        step(); bus.coin_raw = 1'b0;
        lit("t5_c1", int'(bus.credit), 1);
        chk("t5_rej_now", int'(bus.coin_reject), 1);
        step();
        lit("t5_c0", int'(bus.credit), 0);
        chk("t5_idle", int'(bus.state), int'(IDLE));
        wait_cyc(3);
        chk("t5_ret3", n_ret - t0, 3);
        chk("t5_rej1", n_rej - r0, 1);

        // Vend and refund together, with a coin event on the same edge
        coin(2'd3, 4); coin(2'd2, 4);
        lit("t6_c5", int'(bus.credit), 5);
        t0 = n_ret;
        step(); bus.coin_raw = 1'b1; bus.coin_val = 2'd1;
        step(); step(); step();
        bus.vend_req = 1'b1; bus.refund_req = 1'b1;
        step();
        bus.vend_req = 1'b0; bus.refund_req = 1'b0; bus.coin_raw = 1'b0;
        chk("t6_ack", int'(bus.vend_ack), 1);
        chk("t6_rej", int'(bus.coin_reject), 1);
        lit("t6_c0", int'(bus.credit), 0);
        wait_cyc(3);
        chk("t6_no_ret", n_ret - t0, 0);

        // Reset held two cycles in the middle of a refund
        coin(2'd3, 4); coin(2'd3, 4);
        req(1'b0, 1'b1);
        step();
        lit("t1_c4", int'(bus.credit), 4);
        chk("t1_in_refund", int'(bus.state), int'(REFUND));
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        lit("t1_c0", int'(bus.credit), 0);
        chk("t1_pulses", int'({bus.vend_ack, bus.coin_reject, bus.return_pulse}), 0);
        chk("t1_idle", int'(bus.state), int'(IDLE));
        t0 = n_ret;
        wait_cyc(3);
        chk("t1_no_ret", n_ret - t0, 0);
        coin(2'd1, 4); lit("t1_after", int'(bus.credit), 1);

        wait_cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
